// File: rtl/video_pkg.sv
// Shared video timing presets and helpers for the raster scan generator.
package video_pkg;

    // 640x480@60 with a 25 MHz pixel rate
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600@60 with a 40 MHz pixel rate
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    typedef logic [15:0] frame_cnt_t;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pix_ce_div.sv
// Divides clk_100mhz into a one-cycle-wide pixel clock-enable.
module pix_ce_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_100mhz,
    input  logic rstn_i,
    output logic o_pix_ce
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic          r_ce;

    always_comb begin
        w_div_nxt = (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + DW'(1);
    end

    // ce is registered so it is low throughout reset even when CLK_DIV is 1
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            r_div <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_div <= w_div_nxt;
            r_ce  <= (w_div_nxt == DW'(CLK_DIV - 1));
        end
    end

    assign o_pix_ce = r_ce;

endmodule

// File: rtl/video_scan_gen.sv
// Parametrised raster timing generator: sync, data-enable, character-cell
// coordinates and frame/line/vblank strobes, advanced by a pixel clock-enable.
module video_scan_gen
    import video_pkg::*;
#(
    parameter int   CLK_DIV   = 4,
    parameter int   H_ACTIVE  = VGA640_H_ACTIVE,
    parameter int   H_FP      = VGA640_H_FP,
    parameter int   H_SYNC    = VGA640_H_SYNC,
    parameter int   H_BP      = VGA640_H_BP,
    parameter int   V_ACTIVE  = VGA640_V_ACTIVE,
    parameter int   V_FP      = VGA640_V_FP,
    parameter int   V_SYNC    = VGA640_V_SYNC,
    parameter int   V_BP      = VGA640_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   GLYPH_W   = 8,
    parameter int   GLYPH_H   = 8,
    parameter int   HSZ       = 10,
    parameter int   VSZ       = 10
) (
    input  logic                       clk_100mhz,
    input  logic                       rstn_i,
    input  logic                       i_double,
    output logic                       o_pix_ce,
    output logic [HSZ-1:0]             o_hcount,
    output logic [VSZ-1:0]             o_vcount,
    output logic                       o_de,
    output logic                       o_hsync,
    output logic                       o_vsync,
    output logic                       o_double,
    output logic [$clog2(GLYPH_W)-1:0] o_cell_col,
    output logic [$clog2(GLYPH_H)-1:0] o_glyph_row,
    output logic [HSZ-1:0]             o_text_col,
    output logic [VSZ-1:0]             o_text_row,
    output logic                       o_line_start,
    output logic                       o_frame_start,
    output logic                       o_vblank_irq,
    output logic [15:0]                o_frame_cnt
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int CW      = $clog2(GLYPH_W);
    localparam int GW      = $clog2(GLYPH_H);

    if (H_TOTAL > (1 << HSZ)) begin : g_bad_h
        $error("H_TOTAL does not fit in HSZ bits");
    end
    if (V_TOTAL > (1 << VSZ)) begin : g_bad_v
        $error("V_TOTAL does not fit in VSZ bits");
    end
    if ((GLYPH_W < 1) || ((GLYPH_W & (GLYPH_W - 1)) != 0)) begin : g_bad_gw
        $error("GLYPH_W must be a power of 2");
    end
    if ((GLYPH_H < 1) || ((GLYPH_H & (GLYPH_H - 1)) != 0)) begin : g_bad_gh
        $error("GLYPH_H must be a power of 2");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end

    logic             w_pix_ce;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [HSZ-1:0]   w_hcount_nxt;
    logic [VSZ-1:0]   w_vcount_nxt;
    logic             w_at_line;
    logic             w_at_origin;
    logic             w_double_nxt;
    logic [HSZ-1:0]   w_lx;
    logic [VSZ-1:0]   w_ly;

    logic [HSZ-1:0]   r_hcount;
    logic [VSZ-1:0]   r_vcount;
    logic             r_de;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_double;
    logic [CW-1:0]    r_cell_col;
    logic [GW-1:0]    r_glyph_row;
    logic [HSZ-1:0]   r_text_col;
    logic [VSZ-1:0]   r_text_row;
    logic             r_line_start;
    logic             r_frame_start;
    logic             r_vblank_irq;
    frame_cnt_t       r_frame_cnt;
    logic             r_frame_seen;

    pix_ce_div #(.CLK_DIV(CLK_DIV)) u_ce (
        .clk_100mhz (clk_100mhz),
        .rstn_i     (rstn_i),
        .o_pix_ce   (w_pix_ce)
    );

    // Everything is decoded from the next pixel so all outputs register together
    always_comb begin
        w_h_wrap     = (r_hcount == HSZ'(H_TOTAL - 1));
        w_v_wrap     = (r_vcount == VSZ'(V_TOTAL - 1));
        w_hcount_nxt = w_h_wrap ? '0 : r_hcount + HSZ'(1);
        w_vcount_nxt = r_vcount;
        if (w_h_wrap) begin
            w_vcount_nxt = w_v_wrap ? '0 : r_vcount + VSZ'(1);
        end
        w_at_line    = (w_hcount_nxt == '0);
        w_at_origin  = w_at_line && (w_vcount_nxt == '0);
        w_double_nxt = w_at_origin ? i_double : r_double;
        w_lx         = w_double_nxt ? (w_hcount_nxt >> 1) : w_hcount_nxt;
        w_ly         = w_double_nxt ? (w_vcount_nxt >> 1) : w_vcount_nxt;
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            r_hcount      <= HSZ'(H_TOTAL - 1);
            r_vcount      <= VSZ'(V_TOTAL - 1);
            r_de          <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_double      <= 1'b0;
            r_cell_col    <= '0;
            r_glyph_row   <= '0;
            r_text_col    <= '0;
            r_text_row    <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vblank_irq  <= 1'b0;
            r_frame_cnt   <= '0;
            r_frame_seen  <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vblank_irq  <= 1'b0;
            if (w_pix_ce) begin
                r_hcount      <= w_hcount_nxt;
                r_vcount      <= w_vcount_nxt;
                r_de          <= (w_hcount_nxt < HSZ'(H_ACTIVE)) && (w_vcount_nxt < VSZ'(V_ACTIVE));
                r_hsync       <= ((w_hcount_nxt >= HSZ'(H_ACTIVE + H_FP)) &&
                                  (w_hcount_nxt <  HSZ'(H_ACTIVE + H_FP + H_SYNC))) ? HSYNC_POL : ~HSYNC_POL;
                r_vsync       <= ((w_vcount_nxt >= VSZ'(V_ACTIVE + V_FP)) &&
                                  (w_vcount_nxt <  VSZ'(V_ACTIVE + V_FP + V_SYNC))) ? VSYNC_POL : ~VSYNC_POL;
                r_double      <= w_double_nxt;
                r_cell_col    <= w_lx[CW-1:0];
                r_glyph_row   <= w_ly[GW-1:0];
                r_text_col    <= w_lx >> CW;
                r_text_row    <= w_ly >> GW;
                r_line_start  <= w_at_line;
                r_frame_start <= w_at_origin;
                r_vblank_irq  <= w_at_line && (w_vcount_nxt == VSZ'(V_ACTIVE));
                // The first frame after reset reads zero; later frames count up
                if (w_at_origin) begin
                    if (r_frame_seen) begin
                        r_frame_cnt <= r_frame_cnt + frame_cnt_t'(1);
                    end
                    r_frame_seen <= 1'b1;
                end
            end
        end
    end

    assign o_pix_ce      = w_pix_ce;
    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_de          = r_de;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_double      = r_double;
    assign o_cell_col    = r_cell_col;
    assign o_glyph_row   = r_glyph_row;
    assign o_text_col    = r_text_col;
    assign o_text_row    = r_text_row;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_vblank_irq  = r_vblank_irq;
    assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_scan_gen.sv
// Scoreboard bench for video_scan_gen on a reduced 48x31 raster (32x24 visible),
// plus a CLK_DIV=1 instance with active-high hsync.
module tb_video_scan_gen;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic        vb;
        logic        dbl;
        logic [2:0]  cc;
        logic [2:0]  gr;
        logic [9:0]  tc;
        logic [9:0]  tr;
        logic [15:0] fc;
    } pix_t;

    localparam int FRAME_CLK = 48 * 31 * 4;
    localparam int WAIT_LIM  = 3 * FRAME_CLK;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic i_double = 1'b0;

    logic        o_pix_ce, o_de, o_hsync, o_vsync, o_double;
    logic [9:0]  o_hcount, o_vcount, o_text_col, o_text_row;
    logic [2:0]  o_cell_col, o_glyph_row;
    logic        o_line_start, o_frame_start, o_vblank_irq;
    logic [15:0] o_frame_cnt;

    logic        f_pix_ce, f_de, f_hsync, f_vsync, f_double;
    logic [9:0]  f_hcount, f_vcount, f_text_col, f_text_row;
    logic [2:0]  f_cell_col, f_glyph_row;
    logic        f_line_start, f_frame_start, f_vblank_irq;
    logic [15:0] f_frame_cnt;

    int checks = 0;
    int failures = 0;
    pix_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    video_scan_gen #(
        .CLK_DIV(4), .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .GLYPH_W(8), .GLYPH_H(8), .HSZ(10), .VSZ(10)
    ) u_dut (
        .clk_100mhz(clk), .rstn_i(rstn), .i_double(i_double), .o_pix_ce(o_pix_ce),
        .o_hcount(o_hcount), .o_vcount(o_vcount), .o_de(o_de), .o_hsync(o_hsync),
        .o_vsync(o_vsync), .o_double(o_double), .o_cell_col(o_cell_col),
        .o_glyph_row(o_glyph_row), .o_text_col(o_text_col), .o_text_row(o_text_row),
        .o_line_start(o_line_start), .o_frame_start(o_frame_start),
        .o_vblank_irq(o_vblank_irq), .o_frame_cnt(o_frame_cnt)
    );

    video_scan_gen #(
        .CLK_DIV(1), .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .GLYPH_W(8), .GLYPH_H(8), .HSZ(10), .VSZ(10)
    ) u_fast (
        .clk_100mhz(clk), .rstn_i(rstn), .i_double(1'b0), .o_pix_ce(f_pix_ce),
        .o_hcount(f_hcount), .o_vcount(f_vcount), .o_de(f_de), .o_hsync(f_hsync),
        .o_vsync(f_vsync), .o_double(f_double), .o_cell_col(f_cell_col),
        .o_glyph_row(f_glyph_row), .o_text_col(f_text_col), .o_text_row(f_text_row),
        .o_line_start(f_line_start), .o_frame_start(f_frame_start),
        .o_vblank_irq(f_vblank_irq), .o_frame_cnt(f_frame_cnt)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic pix_t mk(input int h, input int v, input bit de, input bit hs, input bit vs,
                                input bit ls, input bit fs, input bit vb, input bit dbl,
                                input int cc, input int gr, input int tc, input int tr, input int fc);
        pix_t p;
        p.h = 10'(h);   p.v = 10'(v);
        p.de = de;      p.hs = hs;     p.vs = vs;
        p.ls = ls;      p.fs = fs;     p.vb = vb;   p.dbl = dbl;
        p.cc = 3'(cc);  p.gr = 3'(gr); p.tc = 10'(tc); p.tr = 10'(tr);
        p.fc = 16'(fc);
        return p;
    endfunction

    task automatic push(input string tag, input pix_t p);
        exp_q.push_back(p);
        tag_q.push_back(tag);
    endtask

    // Monitor: compares each newly presented pixel against the queue head and
    // gathers first-frame statistics
    int pix_frame = 0;
    int stats_done = 0;
    initial begin : monitor
        bit   prev_ce;
        int   ls_hi, vb_hi, fs_hi, hs_lo, vs_lo, de_n;
        pix_t act, req;
        string tag;
        prev_ce = 1'b0;
        ls_hi = 0; vb_hi = 0; fs_hi = 0; hs_lo = 0; vs_lo = 0; de_n = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_ce = 1'b0;
            end else begin
                if (prev_ce && o_hcount == 10'd0 && o_vcount == 10'd0) pix_frame++;
                if (pix_frame == 1) begin
                    ls_hi += int'(o_line_start);
                    vb_hi += int'(o_vblank_irq);
                    fs_hi += int'(o_frame_start);
                    if (prev_ce) begin
                        hs_lo += int'(!o_hsync);
                        vs_lo += int'(!o_vsync);
                        de_n  += int'(o_de);
                    end
                end
                if (pix_frame == 2 && stats_done == 0) begin
                    stats_done = 1;
                    check("frame1_line_start_cycles", ls_hi, 31);
                    check("frame1_vblank_cycles", vb_hi, 1);
                    check("frame1_frame_start_cycles", fs_hi, 1);
                    check("frame1_hsync_low_pixels", hs_lo, 248);
                    check("frame1_vsync_low_pixels", vs_lo, 96);
                    check("frame1_de_pixels", de_n, 768);
                end
                if (prev_ce && exp_q.size() > 0 &&
                    o_hcount == exp_q[0].h && o_vcount == exp_q[0].v) begin
                    req = exp_q.pop_front();
                    tag = tag_q.pop_front();
                    act.h = o_hcount;  act.v = o_vcount;
                    act.de = o_de;     act.hs = o_hsync;  act.vs = o_vsync;
                    act.ls = o_line_start; act.fs = o_frame_start;
                    act.vb = o_vblank_irq; act.dbl = o_double;
                    act.cc = o_cell_col;   act.gr = o_glyph_row;
                    act.tc = o_text_col;   act.tr = o_text_row;
                    act.fc = o_frame_cnt;
                    checks++;
                    if (act !== req) begin
                        failures++;
                        $display("FAIL %s actual=%h required=%h", tag, act, req);
                    end
                end
                prev_ce = o_pix_ce;
            end
        end
    end

    // Periods of ce, line_start and frame_start after the first release
    initial begin : periods
        int cyc, last_ce, last_ls, last_fs, n_ce, n_ls, fs_done;
        @(posedge rstn);
        cyc = 0; last_ce = -1; last_ls = -1; last_fs = -1; n_ce = 0; n_ls = 0; fs_done = 0;
        for (int i = 0; i < FRAME_CLK + 400 && fs_done == 0; i++) begin
            @(negedge clk);
            cyc++;
            if (o_pix_ce) begin
                if (last_ce >= 0 && n_ce < 4) begin
                    check("ce_period", cyc - last_ce, 4);
                    n_ce++;
                end
                last_ce = cyc;
            end
            if (o_line_start) begin
                if (last_ls >= 0 && n_ls < 3) begin
                    check("line_period_clk", cyc - last_ls, 192);
                    n_ls++;
                end
                last_ls = cyc;
            end
            if (o_frame_start) begin
                if (last_fs >= 0) begin
                    check("frame_period_clk", cyc - last_fs, FRAME_CLK);
                    fs_done = 1;
                end
                last_fs = cyc;
            end
        end
        check("frame_period_seen", fs_done, 1);
    end

    // CLK_DIV=1 instance: ce stuck high, 48-clock lines, active-high hsync
    initial begin : fast_chk
        int zeros, cyc, last_ls, ls_done, seen35, seen36;
        @(posedge rstn);
        zeros = 0; cyc = 0; last_ls = -1; ls_done = 0; seen35 = 0; seen36 = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (!f_pix_ce) zeros++;
            if (f_line_start) begin
                if (last_ls >= 0 && ls_done == 0) begin
                    check("fast_line_period_clk", cyc - last_ls, 48);
                    ls_done = 1;
                end
                last_ls = cyc;
            end
            if (f_hcount == 10'd35 && seen35 == 0) begin
                check("fast_hsync_before_window", f_hsync, 0);
                seen35 = 1;
            end
            if (f_hcount == 10'd36 && seen36 == 0) begin
                check("fast_hsync_window_start", f_hsync, 1);
                seen36 = 1;
            end
        end
        check("fast_ce_low_cycles", zeros, 0);
        check("fast_line_period_seen", ls_done, 1);
        check("fast_hsync_window_seen", seen36, 1);
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int n;
        // Frame 1: origin, horizontal porches/sync on line 5, cell decode, vertical timing
        push("f1_origin",       mk( 0, 0, 1,1,1,1,1,0,0, 0,0,0,0, 0));
        push("f1_hfp_last",     mk(35, 5, 0,1,1,0,0,0,0, 3,5,4,0, 0));
        push("f1_hsync_first",  mk(36, 5, 0,0,1,0,0,0,0, 4,5,4,0, 0));
        push("f1_hsync_last",   mk(43, 5, 0,0,1,0,0,0,0, 3,5,5,0, 0));
        push("f1_hbp_first",    mk(44, 5, 0,1,1,0,0,0,0, 4,5,5,0, 0));
        push("f1_line_end",     mk(47, 5, 0,1,1,0,0,0,0, 7,5,5,0, 0));
        push("f1_line6_start",  mk( 0, 6, 1,1,1,1,0,0,0, 0,6,0,0, 0));
        push("f1_px19_17",      mk(19,17, 1,1,1,0,0,0,0, 3,1,2,2, 0));
        push("f1_active_last",  mk(31,17, 1,1,1,0,0,0,0, 7,1,3,2, 0));
        push("f1_hfp_first",    mk(32,17, 0,1,1,0,0,0,0, 0,1,4,2, 0));
        push("f1_last_active",  mk(31,23, 1,1,1,0,0,0,0, 7,7,3,2, 0));
        push("f1_vblank",       mk( 0,24, 0,1,1,1,0,1,0, 0,0,0,3, 0));
        push("f1_vsync_first",  mk( 0,26, 0,1,0,1,0,0,0, 0,2,0,3, 0));
        push("f1_vsync_last",   mk(47,27, 0,1,0,0,0,0,0, 7,3,5,3, 0));
        push("f1_vbp_first",    mk( 0,28, 0,1,1,1,0,0,0, 0,4,0,3, 0));
        push("f1_last_line",    mk( 0,30, 0,1,1,1,0,0,0, 0,6,0,3, 0));
        push("f2_origin",       mk( 0, 0, 1,1,1,1,1,0,0, 0,0,0,0, 1));
        push("f2_px19_17_hold", mk(19,17, 1,1,1,0,0,0,0, 3,1,2,2, 1));

        repeat (3) @(negedge clk);
        check("rst_pix_ce", o_pix_ce, 0);
        check("rst_fast_pix_ce", f_pix_ce, 0);
        check("rst_hcount", o_hcount, 47);
        check("rst_vcount", o_vcount, 30);
        check("rst_de", o_de, 0);
        check("rst_hsync", o_hsync, 1);
        check("rst_vsync", o_vsync, 1);
        check("rst_frame_cnt", o_frame_cnt, 0);
        check("rst_strobes", {o_line_start, o_frame_start, o_vblank_irq}, 0);

        rstn = 1'b1;
        @(negedge clk); check("ce_after_edge1", o_pix_ce, 0);
        @(negedge clk); check("ce_after_edge2", o_pix_ce, 0);
        @(negedge clk); check("ce_after_edge3", o_pix_ce, 1);
        check("hold_before_first_ce", o_hcount, 47);
        @(negedge clk); check("ce_after_edge4", o_pix_ce, 0);
        check("first_pixel_h", o_hcount, 0);
        check("first_frame_start", o_frame_start, 1);
        @(negedge clk); check("frame_start_one_clk", o_frame_start, 0);
        check("hold_between_ce", o_hcount, 0);

        // Request doubling mid-frame 2; it must not apply before frame 3
        n = 0;
        while (n < WAIT_LIM && !(o_frame_cnt == 16'd1 && o_vcount == 10'd10)) begin
            @(negedge clk); n++;
        end
        check("reach_f2_line10", n < WAIT_LIM, 1);
        i_double = 1'b1;
        push("f3_origin_dbl",   mk( 0, 0, 1,1,1,1,1,0,1, 0,0,0,0, 2));
        push("f3_line1_dbl",    mk( 0, 1, 1,1,1,1,0,0,1, 0,0,0,0, 2));
        push("f3_px15_16_dbl",  mk(15,16, 1,1,1,0,0,0,1, 7,0,0,1, 2));
        push("f3_px19_17_dbl",  mk(19,17, 1,1,1,0,0,0,1, 1,0,1,1, 2));

        // Asynchronous reset in the middle of frame 3
        n = 0;
        while (n < WAIT_LIM && !(o_frame_cnt == 16'd2 && o_hcount == 10'd30 && o_vcount == 10'd20)) begin
            @(negedge clk); n++;
        end
        check("reach_f3_px30_20", n < WAIT_LIM, 1);
        check("scoreboard_drained_before_reset", exp_q.size(), 0);
        #2 rstn = 1'b0;
        #1;
        check("midrst_hcount", o_hcount, 47);
        check("midrst_vcount", o_vcount, 30);
        check("midrst_de", o_de, 0);
        check("midrst_hsync", o_hsync, 1);
        check("midrst_vsync", o_vsync, 1);
        check("midrst_frame_cnt", o_frame_cnt, 0);
        check("midrst_double", o_double, 0);
        check("midrst_pix_ce", o_pix_ce, 0);
        check("midrst_text_col", o_text_col, 0);
        i_double = 1'b0;
        push("postrst_origin",  mk( 0, 0, 1,1,1,1,1,0,0, 0,0,0,0, 0));
        push("postrst_px19_17", mk(19,17, 1,1,1,0,0,0,0, 3,1,2,2, 0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        n = 0;
        while (n < WAIT_LIM && exp_q.size() > 0) begin
            @(negedge clk); n++;
        end
        check("scoreboard_leftover", exp_q.size(), 0);
        check("frame1_stats_reported", stats_done, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
